ucsbece154_imem_arb: RTL



---
 rtl/ucsbece154_imem_arb_if.sv | 50 +++++
 rtl/ucsbece154_imem_arb.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/ucsbece154_imem_arb_if.sv
// ucsbece154_imem_arb_if: signal bundle between the instruction-memory
// arbiter, its two requesters (demand-miss path and next-line prefetcher)
// and the single-port burst memory.
//   slave  : arbiter view (accepts requests, drives the memory)
//   master : environment view (requesters and memory)
interface ucsbece154_imem_arb_if #(
   parameter int BLOCK_WORDS     = 4,
   parameter int LOG_BLOCK_WORDS = $clog2(BLOCK_WORDS)
);
   // demand-miss requester
   logic                       dem_req;
   logic [31:0]                dem_addr;
   logic                       dem_grant;
   logic                       dem_ready;
   logic [31:0]                dem_data;
   logic [LOG_BLOCK_WORDS-1:0] dem_block_index;

   // prefetch requester
   logic                       pf_req;
   logic [31:0]                pf_addr;
   logic                       pf_grant;
   logic                       pf_ready;
   logic [31:0]                pf_data;
   logic [LOG_BLOCK_WORDS-1:0] pf_block_index;

   // burst memory
   logic                       mem_ReadRequest;
   logic [31:0]                mem_ReadAddress;
   logic [31:0]                mem_DataIn;
   logic                       mem_DataReady;
   logic [LOG_BLOCK_WORDS-1:0] mem_block_index;

   modport slave (
      input  dem_req, dem_addr,
      output dem_grant, dem_ready, dem_data, dem_block_index,
      input  pf_req, pf_addr,
      output pf_grant, pf_ready, pf_data, pf_block_index,
      output mem_ReadRequest, mem_ReadAddress,
      input  mem_DataIn, mem_DataReady, mem_block_index
   );

   modport master (
      output dem_req, dem_addr,
      input  dem_grant, dem_ready, dem_data, dem_block_index,
      output pf_req, pf_addr,
      input  pf_grant, pf_ready, pf_data, pf_block_index,
      input  mem_ReadRequest, mem_ReadAddress,
      output mem_DataIn, mem_DataReady, mem_block_index
   );
endinterface

// File: rtl/ucsbece154_imem_arb.sv
// ucsbece154_imem_arb: two-requester arbiter and burst sequencer in front of
// the single-port instruction memory. Demand misses win over prefetches.
// Each burst gets one ReadRequest pulse, a ReadAddress held for the whole
// fetch, and BLOCK_WORDS counted beats that are steered to the owner.
//
// Optional feature, macro IMEM_ARB_MERGE_EN: a demand miss for the block a
// prefetch is already fetching piggybacks on that burst instead of waiting.
// Beats then arrive in prefetch order, not critical-word-first.
module ucsbece154_imem_arb #(
   parameter int BLOCK_WORDS     = 4,
   parameter int LOG_BLOCK_WORDS = $clog2(BLOCK_WORDS)
) (
   input logic                  clk,
   input logic                  reset,
   ucsbece154_imem_arb_if.slave bus
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] BUSY  = 2'd2;

   localparam logic [1:0] OWN_NONE = 2'd0;
   localparam logic [1:0] OWN_DEM  = 2'd1;
   localparam logic [1:0] OWN_PF   = 2'd2;

   localparam logic [LOG_BLOCK_WORDS-1:0] LAST_BEAT = LOG_BLOCK_WORDS'(BLOCK_WORDS - 1);

   // Lowest address bit that identifies a block (byte address, 4-byte words).
   localparam int TAG_LSB = LOG_BLOCK_WORDS + 2;

   logic [1:0]                 state;
   logic [1:0]                 owner;
   logic [LOG_BLOCK_WORDS-1:0] beat_cnt;
   logic                       merged;
   logic                       read_request;
   logic [31:0]                read_address;
   logic                       dem_grant;
   logic                       pf_grant;

   logic                       beat;
   logic                       last_beat;
   logic                       arb_open;
   logic                       dem_sel;
   logic                       pf_sel;
   logic                       merge_hit;

   assign beat      = (state == BUSY) & bus.mem_DataReady;
   assign last_beat = beat & (beat_cnt == LAST_BEAT);

   // The memory is idle again in the cycle after its last beat, so the edge
   // that retires the last beat may already select the next burst.
   assign arb_open = (state == IDLE) | last_beat;
   assign dem_sel  = arb_open & bus.dem_req;
   assign pf_sel   = arb_open & ~bus.dem_req & bus.pf_req;

`ifdef IMEM_ARB_MERGE_EN
   // A demand for the block of a prefetch that has not delivered anything yet
   // joins that burst. A beat arriving in the same cycle would be lost to the
   // demand side, so the merge waits one cycle in that case.
   assign merge_hit = (state == BUSY) & (owner == OWN_PF) & ~merged &
                      (beat_cnt == '0) & ~bus.mem_DataReady & bus.dem_req &
                      (bus.dem_addr[31:TAG_LSB] == read_address[31:TAG_LSB]);

   // Merge flag: set by a joining demand, cleared when the burst retires.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         merged <= 1'b0;
      end else if (last_beat) begin
         merged <= 1'b0;
      end else if (merge_hit) begin
         merged <= 1'b1;
      end
   end
`else
   assign merge_hit = 1'b0;
   assign merged    = 1'b0;
`endif

   // Burst sequencer: arbitration, request pulse, address hold, beat count.
   // NOTE: every register here is sequential state, so only non-blocking
   // assignments are used; the reset branch covers all of them because the
   // block may be reset in the middle of a burst.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         owner        <= OWN_NONE;
         beat_cnt     <= '0;
         read_request <= 1'b0;
         read_address <= '0;
         dem_grant    <= 1'b0;
         pf_grant     <= 1'b0;
      end else begin
         // Request and grants are single-cycle pulses unless re-armed below.
         read_request <= 1'b0;
         dem_grant    <= merge_hit;
         pf_grant     <= 1'b0;

         if (dem_sel | pf_sel) begin
            state        <= ISSUE;
            owner        <= dem_sel ? OWN_DEM : OWN_PF;
            read_address <= dem_sel ? bus.dem_addr : bus.pf_addr;
            read_request <= 1'b1;
            dem_grant    <= dem_sel;
            pf_grant     <= pf_sel;
            beat_cnt     <= '0;
         end else begin
            case (state)
               ISSUE: state <= BUSY;
               BUSY: begin
                  if (beat) begin
                     if (last_beat) begin
                        beat_cnt <= '0;
                        owner    <= OWN_NONE;
                        state    <= IDLE;
                     end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   // Memory side: registered pulse and address.
   assign bus.mem_ReadRequest = read_request;
   assign bus.mem_ReadAddress = read_address;

   // Requester side: grants, and beats steered to the owner without latency.
   assign bus.dem_grant       = dem_grant;
   assign bus.pf_grant        = pf_grant;
   assign bus.dem_ready       = bus.mem_DataReady & ((owner == OWN_DEM) | merged);
   assign bus.pf_ready        = bus.mem_DataReady & (owner == OWN_PF);
   assign bus.dem_data        = bus.mem_DataIn;
   assign bus.pf_data         = bus.mem_DataIn;
   assign bus.dem_block_index = bus.mem_block_index;
   assign bus.pf_block_index  = bus.mem_block_index;

`ifdef SIM
   // The memory must only return data for a burst this block started.
   assert property (@(posedge clk) disable iff (reset)
                    bus.mem_DataReady |-> (state == BUSY));
`endif

endmodule
